// File: rtl/multiplier_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_seq_pkg
// Description : Shared sequential-arithmetic definitions (state encoding and
//               default operand width) used by the shift-add multiplier, the
//               sequential divider and their benches.
// Revision    : 1.0 - initial release
// ============================================================================
package multiplier_seq_pkg;

    // Default operand width for the sequential arithmetic blocks
    localparam int c_default_width = 16;

    // Handshake FSM shared by the divider and the multiplier
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage : multiplier_seq_pkg
`default_nettype wire

// File: rtl/multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_seq
// Description : Sequential shift-add multiply-accumulate, p = q * b + r.
//               Fixed latency of WIDTH iterations, start/done handshake,
//               fits flags results that are legal WIDTH-bit dividends.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_seq
    import multiplier_seq_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic                 clk,
    input  logic                 rst,      // asynchronous, active-low
    input  logic                 start,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     r,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p,
    output logic                 fits
);

    localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    seq_state_t           r_state;
    seq_state_t           w_state_next;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   w_acc_iter;
    logic                 w_accept;
    logic                 w_last;

    // One shift-add step: conditionally add the shifted multiplicand.
    // The accumulator is sized for the worst case (2^2W - 2^W), so no carry-out.
    always_comb begin
        w_acc_iter = r_acc;
        if (r_mplier[0]) begin
            w_acc_iter = r_acc + r_mcand;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_last_cnt) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result capture on DONE entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            p        <= '0;
            fits     <= 1'b1;
        end else begin
            if (w_accept) begin
                r_acc    <= {{WIDTH{1'b0}}, r};
                r_mcand  <= {{WIDTH{1'b0}}, b};
                r_mplier <= q;
                r_cnt    <= '0;
            end else if (r_state == ST_RUN) begin
                r_acc    <= w_acc_iter;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
            // p/fits are only updated here, so they hold across later starts
            if (w_last) begin
                p    <= w_acc_iter;
                fits <= (w_acc_iter[2*WIDTH-1:WIDTH] == '0);
            end
        end
    end

endmodule : multiplier_seq
`default_nettype wire

// File: tb/tb_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_seq
// Description : Scoreboard bench for multiplier_seq: directed vectors push
//               expected results; a monitor checks them on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_seq;

    localparam int WIDTH = 16;

    typedef struct {
        logic [2*WIDTH-1:0] p;
        logic               fits;
        int                 cyc;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    q;
    logic [WIDTH-1:0]    b;
    logic [WIDTH-1:0]    r;
    logic                busy;
    logic                done;
    logic [2*WIDTH-1:0]  p;
    logic                fits;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   chk_low  = 1'b0;

    multiplier_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q     (q),
        .b     (b),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .fits  (fits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts negedges, checks every done pulse against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (chk_low) begin
            chk_low = 1'b0;
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("busy_after_done", {31'd0, busy}, 32'd0);
        end
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("p", p, e.p);
                check("fits", {31'd0, fits}, {31'd0, e.fits});
                check("latency", cyc, e.cyc);
                chk_low = 1'b1;
            end
        end
    end

    // Move to a point just after a falling edge
    task automatic align();
        @(negedge clk);
        #1;
    endtask

    // Must be called right after align(); drives a one-cycle start
    task automatic start_op(input logic [WIDTH-1:0] iq, input logic [WIDTH-1:0] ib,
                            input logic [WIDTH-1:0] ir, input logic [31:0] ep,
                            input logic ef, input bit push);
        exp_t e;
        q     = iq;
        b     = ib;
        r     = ir;
        start = 1'b1;
        if (push) begin
            e.p    = ep;
            e.fits = ef;
            e.cyc  = cyc + 17;
            sbq.push_back(e);
        end
        align();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && sbq.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sbq.size() != 0) begin
            check("done_timeout", 32'd1, 32'd0);
            sbq.delete();
        end
        align();
        align();
    endtask

    initial begin
        int k;
        rst   = 1'b0;
        start = 1'b0;
        q     = '0;
        b     = '0;
        r     = '0;

        // Reset sequence: low, high, low, high
        #100;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_p", p, 32'd0);
        check("rst_fits", {31'd0, fits}, 32'd1);
        align();
        rst = 1'b1;
        align();
        align();
        rst = 1'b0;
        align();
        align();
        // Release and start in the same cycle: first edge with rst=1 accepts
        rst = 1'b1;
        start_op(16'd33, 16'd3, 16'd1, 32'd100, 1'b1, 1'b1);
        wait_idle();

        // Back-to-back operations without reset
        align();
        start_op(16'd51, 16'd5, 16'd0, 32'd255, 1'b1, 1'b1);
        wait_idle();
        start_op(16'd22, 16'd56, 16'd2, 32'd1234, 1'b1, 1'b1);
        wait_idle();

        // Largest operands, and zero multiplier with full latency
        start_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000, 1'b0, 1'b1);
        wait_idle();
        check("hold_p_after_done", p, 32'hFFFF_0000);
        start_op(16'd0, 16'h1234, 16'd7, 32'd7, 1'b1, 1'b1);
        wait_idle();

        // Start held high for 40 cycles with q=3j+1, b=j+2, r=j after edge 0:
        // accepts at edges 0, 18 and 36
        k     = cyc;
        q     = 16'd10;
        b     = 16'd20;
        r     = 16'd5;
        start = 1'b1;
        sbq.push_back('{p: 32'd205,  fits: 1'b1, cyc: k + 17});
        sbq.push_back('{p: 32'd1118, fits: 1'b1, cyc: k + 35});
        sbq.push_back('{p: 32'd4178, fits: 1'b1, cyc: k + 53});
        for (int j = 1; j < 40; j++) begin
            align();
            q = 16'(3 * j + 1);
            b = 16'(j + 2);
            r = 16'(j);
        end
        align();
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-RUN aborts without a done
        start_op(16'd100, 16'd200, 16'd3, 32'd0, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_p", p, 32'd0);
        check("abort_fits", {31'd0, fits}, 32'd1);
        repeat (20) align();
        check("abort_p_held", p, 32'd0);
        rst = 1'b1;
        start_op(16'd7, 16'd9, 16'd3, 32'd66, 1'b1, 1'b1);
        wait_idle();

        // Divide-then-multiply self-check: 1234 / 56 = 22 rem 2
        start_op(16'd22, 16'd56, 16'd2, 32'd1234, 1'b1, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multiplier_seq
`default_nettype wire
